parking_gate_array: RTL and testbench

//  Parametrised multi-gate car park controller, successor to the single-gate counter chain.

---
 rtl/park_pkg.sv | 29 ++
 rtl/gate_dir_fsm.sv | 153 +++++++++++++++
 rtl/parking_gate_array.sv | 102 ++++++++++
 tb/tb_parking_gate_array.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Package: park_pkg
// Shared types and helpers for the parking_gate_array car park controller.
//   gate_state_t : per-gate direction FSM state encoding
//   popcount     : counts set bits of a gate event vector (zero-extend to MAX_GATES)
package park_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        IN3  = 3'd3,
        OUT1 = 3'd4,
        OUT2 = 3'd5,
        OUT3 = 3'd6
    } gate_state_t;

    // Widest gate vector popcount accepts; callers zero-extend narrower vectors.
    localparam int MAX_GATES = 32;

    function automatic logic [5:0] popcount(input logic [MAX_GATES-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_GATES; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_dir_fsm.sv
// Module: gate_dir_fsm
// Direction decoder for one gate. Tracks the outer (a) / inner (b) beam
// pattern and emits a registered one-cycle pulse on a completed entry or exit.
// Optional feature macro: PARK_SEQ_ERR_EN (adds seq_err and resync on illegal steps).
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high
//   sensor_a  in   outer beam broken
//   sensor_b  in   inner beam broken
//   car_in    out  1-cycle pulse, completed entry
//   car_out   out  1-cycle pulse, completed exit
//   seq_err   out  1-cycle pulse, illegal sensor step (PARK_SEQ_ERR_EN only)
//
// state | meaning
// IDLE  | no car in the gate, {a,b} = 00
// IN1   | entering, outer beam only (10)
// IN2   | entering, both beams (11)
// IN3   | entering, inner beam only (01)
// OUT1  | leaving, inner beam only (01)
// OUT2  | leaving, both beams (11)
// OUT3  | leaving, outer beam only (10)
module gate_dir_fsm
    import park_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic car_in,
    output logic car_out
`ifdef PARK_SEQ_ERR_EN
    ,
    output logic seq_err
`endif
);

    gate_state_t state, next_state;
    logic [1:0]  ab;
    logic        entry_done;
    logic        exit_done;
    logic        illegal;

    assign ab = {sensor_a, sensor_b};

    always_comb begin
        next_state = state;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            IDLE: begin
                case (ab)
                    2'b10:   next_state = IN1;
                    2'b01:   next_state = OUT1;
                    2'b00:   next_state = IDLE;
                    default: illegal = 1'b1;
                endcase
            end
            IN1: begin
                case (ab)
                    2'b11:   next_state = IN2;
                    2'b00:   next_state = IDLE;
                    2'b10:   next_state = IN1;
                    default: illegal = 1'b1;
                endcase
            end
            IN2: begin
                case (ab)
                    2'b01:   next_state = IN3;
                    2'b10:   next_state = IN1;
                    2'b11:   next_state = IN2;
                    default: illegal = 1'b1;
                endcase
            end
            IN3: begin
                case (ab)
                    2'b00: begin
                        next_state = IDLE;
                        entry_done = 1'b1;
                    end
                    2'b11:   next_state = IN2;
                    2'b01:   next_state = IN3;
                    default: illegal = 1'b1;
                endcase
            end
            OUT1: begin
                case (ab)
                    2'b11:   next_state = OUT2;
                    2'b00:   next_state = IDLE;
                    2'b01:   next_state = OUT1;
                    default: illegal = 1'b1;
                endcase
            end
            OUT2: begin
                case (ab)
                    2'b10:   next_state = OUT3;
                    2'b01:   next_state = OUT1;
                    2'b11:   next_state = OUT2;
                    default: illegal = 1'b1;
                endcase
            end
            OUT3: begin
                case (ab)
                    2'b00: begin
                        next_state = IDLE;
                        exit_done  = 1'b1;
                    end
                    2'b11:   next_state = OUT2;
                    2'b10:   next_state = OUT3;
                    default: illegal = 1'b1;
                endcase
            end
            default: next_state = IDLE;
        endcase

`ifdef PARK_SEQ_ERR_EN
        // Resynchronise to whatever the beams currently show.
        if (illegal) begin
            if (ab == 2'b10)
                next_state = IN1;
            else if (ab == 2'b01)
                next_state = OUT1;
            else
                next_state = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            car_in  <= 1'b0;
            car_out <= 1'b0;
`ifdef PARK_SEQ_ERR_EN
            seq_err <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            car_in  <= entry_done;
            car_out <= exit_done;
`ifdef PARK_SEQ_ERR_EN
            seq_err <= illegal;
`endif
        end
    end

`ifndef PARK_SEQ_ERR_EN
    // Illegal steps are simply ignored (state holds) in this build.
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

// File: rtl/parking_gate_array.sv
// Module: parking_gate_array
// Multi-gate car park controller: one gate_dir_fsm per gate feeding a shared
// saturating occupancy counter with full/empty status and clip pulses.
// Optional feature macro: PARK_SEQ_ERR_EN (adds the per-gate seq_err output).
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high
//   sensor_a   in   [N_GATES] outer beam per gate
//   sensor_b   in   [N_GATES] inner beam per gate
//   car_in     out  [N_GATES] entry pulse per gate
//   car_out    out  [N_GATES] exit pulse per gate
//   occupancy  out  [CNT_W]   cars inside
//   full       out  occupancy == CAPACITY
//   empty      out  occupancy == 0
//   overflow   out  1-cycle pulse, entries clipped at CAPACITY
//   underflow  out  1-cycle pulse, exits clipped at 0
//   seq_err    out  [N_GATES] illegal step pulse (PARK_SEQ_ERR_EN only)
module parking_gate_array
    import park_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 7,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] sensor_a,
    input  logic [N_GATES-1:0] sensor_b,
    output logic [N_GATES-1:0] car_in,
    output logic [N_GATES-1:0] car_out,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow
`ifdef PARK_SEQ_ERR_EN
    ,
    output logic [N_GATES-1:0] seq_err
`endif
);

    localparam int EV_W  = CNT_W + 2;
    // One spare bit beyond the event width keeps occupancy + n_in from wrapping.
    localparam int SUM_W = CNT_W + 3;

    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        gate_dir_fsm u_fsm (
            .clk      (clk),
            .reset    (reset),
            .sensor_a (sensor_a[g]),
            .sensor_b (sensor_b[g]),
            .car_in   (car_in[g]),
            .car_out  (car_out[g])
`ifdef PARK_SEQ_ERR_EN
            ,
            .seq_err  (seq_err[g])
`endif
        );
    end

    logic [EV_W-1:0]         n_in;
    logic [EV_W-1:0]         n_out;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        occ_next;
    logic                    ovf_next;
    logic                    unf_next;

    always_comb begin
        n_in     = EV_W'(popcount(MAX_GATES'(car_in)));
        n_out    = EV_W'(popcount(MAX_GATES'(car_out)));
        sum      = $signed({3'b000, occupancy}) + $signed({1'b0, n_in})
                 - $signed({1'b0, n_out});
        occ_next = sum[CNT_W-1:0];
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (sum > CAP_S) begin
            occ_next = CNT_W'(CAPACITY);
            ovf_next = 1'b1;
        end else if (sum < 0) begin
            occ_next = '0;
            unf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            occupancy <= occ_next;
            overflow  <= ovf_next;
            underflow <= unf_next;
        end
    end

    assign full  = (occupancy == CNT_W'(CAPACITY));
    assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_gate_array.sv
module tb_parking_gate_array;

    localparam int N   = 2;
    localparam int CAP = 7;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  sensor_a;
    logic [N-1:0]  sensor_b;
    logic [N-1:0]  car_in;
    logic [N-1:0]  car_out;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
`ifdef PARK_SEQ_ERR_EN
    logic [N-1:0]  seq_err;
`endif

    parking_gate_array #(.N_GATES(N), .CAPACITY(CAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .car_in    (car_in),
        .car_out   (car_out),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef PARK_SEQ_ERR_EN
        ,
        .seq_err   (seq_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ci;
        logic [1:0] co;
        logic       ov;
        logic       un;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  errors = 0;
    int  checks = 0;
    int  seq_err_cnt = 0;

    // Every cycle with any pulse is recorded for the scoreboard.
    always @(negedge clk) begin
        if ((|car_in) || (|car_out) || overflow || underflow)
            obs_q.push_back('{car_in, car_out, overflow, underflow});
`ifdef PARK_SEQ_ERR_EN
        if (seq_err[0])
            seq_err_cnt++;
`endif
    end

    task automatic step(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        sensor_a = a;
        sensor_b = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        sensor_a = '0;
        sensor_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic enter_gate0(input int n);
        for (int i = 0; i < n; i++) begin
            step(2'b01, 2'b00);
            step(2'b01, 2'b01);
            step(2'b00, 2'b01);
            step(2'b00, 2'b00);
        end
        idle(3);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: occ=%0d empty=%b full=%b, need occ=0 empty=1 full=0",
                     occupancy, empty, full);
        end
        checks++;
        if (car_in !== 2'b00 || car_out !== 2'b00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: ci=%b co=%b ov=%b un=%b, need all 0",
                     car_in, car_out, overflow, underflow);
        end
    endtask

    task automatic test_single_entry();
        do_reset();
        obs_q.delete();
        exp_q.push_back('{2'b01, 2'b00, 1'b0, 1'b0});
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        step(2'b00, 2'b01);
        step(2'b00, 2'b00);
        // Pulse visible at the next negedge, occupancy one cycle later.
        @(negedge clk);
        checks++;
        if (car_in !== 2'b01) begin
            errors++;
            $display("FAIL t1_pulse_timing: car_in=%b, need 01", car_in);
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL t1_occ: occ=%0d empty=%b, need occ=1 empty=0", occupancy, empty);
        end
        idle(2);
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t1_event: missing event, need %b", e);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL t1_event: got %b, need %b", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t1_extra: %0d extra events, need 0", obs_q.size());
        end
    endtask

    task automatic test_exit_backup();
        do_reset();
        enter_gate0(3);
        obs_q.delete();
        exp_q.push_back('{2'b00, 2'b10, 1'b0, 1'b0});
        // gate1 {a,b}: 01,11,01,11,10,00
        step(2'b00, 2'b10);
        step(2'b10, 2'b10);
        step(2'b00, 2'b10);
        step(2'b10, 2'b10);
        step(2'b10, 2'b00);
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL t2_occ: occ=%0d, need 2", occupancy);
        end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t2_event: missing event, need %b", e);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL t2_event: got %b, need %b", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t2_extra: %0d extra events, need 0", obs_q.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        enter_gate0(4);
        obs_q.delete();
        exp_q.push_back('{2'b01, 2'b10, 1'b0, 1'b0});
        // gate0 entry 10,11,01,00 alongside gate1 exit 01,11,10,00
        step(2'b01, 2'b10);
        step(2'b11, 2'b11);
        step(2'b10, 2'b01);
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("FAIL t3_occ: occ=%0d, need 4", occupancy);
        end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t3_event: missing event, need %b", e);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL t3_event: got %b, need %b", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t3_extra: %0d extra events, need 0", obs_q.size());
        end
    endtask

    task automatic test_overflow();
        int ov_seen;
        do_reset();
        obs_q.delete();
        enter_gate0(CAP);
        ov_seen = 0;
        foreach (obs_q[i]) if (obs_q[i].ov) ov_seen++;
        checks++;
        if (occupancy !== 3'd7 || full !== 1'b1 || ov_seen != 0) begin
            errors++;
            $display("FAIL t4_fill: occ=%0d full=%b ov=%0d, need occ=7 full=1 ov=0",
                     occupancy, full, ov_seen);
        end
        obs_q.delete();
        exp_q.push_back('{2'b11, 2'b00, 1'b0, 1'b0});
        exp_q.push_back('{2'b00, 2'b00, 1'b1, 1'b0});
        step(2'b11, 2'b00);
        step(2'b11, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (occupancy !== 3'd7 || full !== 1'b1) begin
            errors++;
            $display("FAIL t4_occ: occ=%0d full=%b, need occ=7 full=1", occupancy, full);
        end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t4_event: missing event, need %b", e);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL t4_event: got %b, need %b", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t4_extra: %0d extra events, need 0", obs_q.size());
        end
    endtask

    task automatic test_underflow();
        do_reset();
        obs_q.delete();
        exp_q.push_back('{2'b00, 2'b01, 1'b0, 1'b0});
        exp_q.push_back('{2'b00, 2'b00, 1'b0, 1'b1});
        // gate0 exit 01,11,10,00
        step(2'b00, 2'b01);
        step(2'b01, 2'b01);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (occupancy !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL t5_occ: occ=%0d empty=%b, need occ=0 empty=1", occupancy, empty);
        end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t5_event: missing event, need %b", e);
            end else begin
                ev_t o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL t5_event: got %b, need %b", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL t5_extra: %0d extra events, need 0", obs_q.size());
        end
    endtask

    task automatic test_abort_illegal();
        do_reset();
        obs_q.delete();
        seq_err_cnt = 0;
        // Abort: 10,00
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        idle(2);
        // Illegal 11 from IDLE, then 01,00: an FSM left in IDLE (or resynced
        // to IDLE) sees an aborted exit; a wrongly advanced one would emit.
        step(2'b01, 2'b01);
        step(2'b00, 2'b01);
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (obs_q.size() != 0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL t6_abort_illegal: events=%0d occ=%0d, need events=0 occ=0",
                     obs_q.size(), occupancy);
        end
`ifdef PARK_SEQ_ERR_EN
        checks++;
        if (seq_err_cnt != 1) begin
            errors++;
            $display("FAIL t6_seq_err: pulses=%0d, need 1", seq_err_cnt);
        end
`endif
        // Reset in IN2 discards the partial entry.
        enter_gate0(2);
        obs_q.delete();
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        sensor_a = 2'b00;
        sensor_b = 2'b01;
        step(2'b00, 2'b00);
        idle(3);
        checks++;
        if (occupancy !== 3'd0 || empty !== 1'b1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL t6_reset_mid: occ=%0d empty=%b events=%0d, need occ=0 empty=1 events=0",
                     occupancy, empty, obs_q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        sensor_a = '0;
        sensor_b = '0;
        test_reset();
        test_single_entry();
        test_exit_backup();
        test_simultaneous();
        test_overflow();
        test_underflow();
        test_abort_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
